// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if;
  logic [7:0] sign_a;
  logic       tick_a;
  logic [7:0] sign_b;
  logic       tick_b;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       full_a;
  logic       full_b;
  logic       drop_a;
  logic       drop_b;
  logic [1:0] owner;

  // Environment side: requesters and UART transmitter.
  modport master (
    output sign_a, tick_a, sign_b, tick_b, tx_busy,
    input  tx_data, tx_start, full_a, full_b, drop_a, drop_b, owner
  );

  // Arbiter side.
  modport slave (
    input  sign_a, tick_a, sign_b, tick_b, tx_busy,
    output tx_data, tx_start, full_a, full_b, drop_a, drop_b, owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmit arbiter: per-port FIFOs, frame-granular
// ownership released on the end-of-line byte or after a stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  EOL_CHAR    = 8'd10,
  parameter int unsigned STALL_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_t;

  state_t        r_state, w_next;
  owner_t        r_owner, r_last, w_grant_sel;
  logic [SW-1:0] r_stall;
  logic [7:0]    r_tx_data;
  logic          r_tx_start;

  logic          w_load, w_grant, w_stall_inc, w_release, w_owner_ne;
  logic [1:0]    w_tick, w_ne, w_full_v, w_drop_v;
  logic [7:0]    w_sign [2];
  logic [7:0]    w_head [2];

  assign w_tick[0] = bus.tick_a;
  assign w_tick[1] = bus.tick_b;
  assign w_sign[0] = bus.sign_a;
  assign w_sign[1] = bus.sign_b;

  // Index 0 is requester A, index 1 is requester B.
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_drop;
    logic          w_full, w_push, w_pop;

    // Fullness is judged on the count at the start of the cycle, so a pop
    // in the same cycle never makes room for a tick on a full FIFO.
    assign w_full = (r_cnt == CW'(FIFO_DEPTH));
    assign w_push = w_tick[g] && !w_full;
    assign w_pop  = w_load && (r_owner == ((g == 0) ? OWN_A : OWN_B));

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_sign[g];
    end

    // Pointers, occupancy and drop pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_drop <= 1'b0;
      end else begin
        r_drop <= w_tick[g] && w_full;
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
        if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
        else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_ne[g]     = (r_cnt != '0);
    assign w_full_v[g] = w_full;
    assign w_drop_v[g] = r_drop;
    assign w_head[g]   = r_mem[r_rp];
  end

  assign w_owner_ne = ((r_owner == OWN_A) && w_ne[0]) ||
                      ((r_owner == OWN_B) && w_ne[1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_owner == OWN_NONE) begin
          if (w_ne != 2'b00) w_next = S_LOAD;
        end else if (w_owner_ne) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD:      w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.tx_busy)  w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.tx_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    w_load      = (r_state == S_LOAD);
    w_grant     = (r_state == S_IDLE) && (r_owner == OWN_NONE) && (w_ne != 2'b00);
    w_stall_inc = (r_state == S_IDLE) && (r_owner != OWN_NONE) && !w_owner_ne;
    w_release   = (r_state == S_WAIT_DONE) && !bus.tx_busy && (r_tx_data == EOL_CHAR);
    w_grant_sel = OWN_NONE;
    if (w_ne == 2'b11)   w_grant_sel = (r_last == OWN_A) ? OWN_B : OWN_A;
    else if (w_ne[0])    w_grant_sel = OWN_A;
    else if (w_ne[1])    w_grant_sel = OWN_B;
  end

  // Ownership, fairness memory and stall timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_last  <= OWN_B;
      r_stall <= '0;
    end else begin
      if (w_grant) r_owner <= w_grant_sel;
      if (w_release) begin
        r_last  <= r_owner;
        r_owner <= OWN_NONE;
      end
      if (w_load) begin
        r_stall <= '0;
      end else if (w_stall_inc) begin
        if (r_stall == SW'(STALL_LIMIT - 1)) begin
          r_stall <= '0;
          r_owner <= OWN_NONE;
        end else begin
          r_stall <= r_stall + 1'b1;
        end
      end
    end
  end

  // Transmit byte and start pulse; start is raised on the LOAD edge so it
  // is high exactly while the FSM sits in START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_load;
      if (w_load) r_tx_data <= (r_owner == OWN_B) ? w_head[1] : w_head[0];
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.full_a   = w_full_v[0];
  assign bus.full_b   = w_full_v[1];
  assign bus.drop_a   = w_drop_v[0];
  assign bus.drop_b   = w_drop_v[1];
  assign bus.owner    = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART busy model.
module tb_uart_tx_arbiter;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned STALL = 20;
  localparam int          BUSY  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if ifc ();

  uart_tx_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .EOL_CHAR   (8'h0A),
    .STALL_LIMIT(STALL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_start = 0;
  int         n_drop_a = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;
  logic       allow_stall = 1'b0;
  logic       prev_start = 1'b0;
  logic [1:0] frame_port = 2'b00;
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [1:0] own_log [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model and scoreboard: answers each start pulse with BUSY cycles of
  // tx_busy and checks the byte against the owning port's expected queue.
  initial begin
    ifc.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.drop_a) n_drop_a++;
      if (rst) begin
        ifc.tx_busy = 1'b0;
        busy_cnt    = 0;
        frame_port  = 2'b00;
        prev_start  = 1'b0;
      end else begin
        if (ifc.tx_start) begin
          check_val("start_width", prev_start, 0);
          n_start++;
          own_log.push_back(ifc.owner);
          check_val("owner_valid", (ifc.owner == 2'b01) || (ifc.owner == 2'b10), 1);
          if (frame_port != 2'b00 && !allow_stall)
            check_val("no_interleave", ifc.owner, frame_port);
          if (ifc.owner == 2'b01) begin
            check_val("sb_avail_a", qa.size() != 0, 1);
            if (qa.size() != 0) cur_exp = qa.pop_front();
          end else if (ifc.owner == 2'b10) begin
            check_val("sb_avail_b", qb.size() != 0, 1);
            if (qb.size() != 0) cur_exp = qb.pop_front();
          end
          check_val("tx_data", ifc.tx_data, cur_exp);
          frame_port  = (cur_exp == 8'h0A) ? 2'b00 : ifc.owner;
          busy_cnt    = BUSY;
          ifc.tx_busy = 1'b1;
        end else begin
          if (ifc.tx_busy) check_val("tx_data_stable", ifc.tx_data, cur_exp);
          if (busy_cnt > 0) busy_cnt--;
          if (busy_cnt == 0 && !hold_busy) ifc.tx_busy = 1'b0;
        end
        prev_start = ifc.tx_start;
      end
    end
  end

  task automatic drive(input logic ta, input logic [7:0] da,
                       input logic tbv, input logic [7:0] db, input logic keep);
    ifc.tick_a = ta;  ifc.sign_a = da;
    ifc.tick_b = tbv; ifc.sign_b = db;
    if (keep && ta)  qa.push_back(da);
    if (keep && tbv) qb.push_back(db);
    @(negedge clk);
    ifc.tick_a = 1'b0;
    ifc.tick_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_start < target; i++) @(negedge clk);
    check_val(tag, n_start >= target, 1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && ifc.owner == 2'b00 && !ifc.tx_busy) break;
      @(negedge clk);
    end
    check_val(tag, (qa.size() == 0) && (qb.size() == 0) && (ifc.owner == 2'b00), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int drops0;
    logic [7:0] fa [3];
    logic [7:0] fb [3];
    fa = '{8'h31, 8'h32, 8'h0A};
    fb = '{8'h61, 8'h62, 8'h0A};
    ifc.tick_a = 1'b0; ifc.sign_a = 8'h00;
    ifc.tick_b = 1'b0; ifc.sign_b = 8'h00;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tx_data",  ifc.tx_data, 8'h00);
    check_val("rst_tx_start", ifc.tx_start, 0);
    check_val("rst_full",     {ifc.full_a, ifc.full_b}, 0);
    check_val("rst_drop",     {ifc.drop_a, ifc.drop_b}, 0);
    check_val("rst_owner",    ifc.owner, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // "V01\n" from A: start pulse in cycle 3, four bytes, owner released
    base = n_start;
    drive(1, 8'h56, 0, 8'h00, 1);
    check_val("lat_c1", ifc.tx_start, 0);
    drive(1, 8'h30, 0, 8'h00, 1);
    check_val("lat_c2", ifc.tx_start, 0);
    drive(1, 8'h31, 0, 8'h00, 1);
    check_val("lat_c3", ifc.tx_start, 1);
    drive(1, 8'h0A, 0, 8'h00, 1);
    wait_drain(300, "v01_drain");
    check_val("v01_count", n_start - base, 4);
    check_val("v01_owner", ifc.owner, 2'b00);

    // Simultaneous A and B frames after reset: A first, no interleave
    do_reset();
    base = n_start;
    for (int i = 0; i < 3; i++) drive(1, fa[i], 1, fb[i], 1);
    wait_drain(400, "ab_drain");
    check_val("ab_count", n_start - base, 6);
    if (own_log.size() >= base + 6) begin
      check_val("ab_first_a", own_log[base], 2'b01);
      check_val("ab_then_b",  own_log[base + 3], 2'b10);
    end else begin
      check_val("ab_log", own_log.size(), base + 6);
    end

    // Overflow of A while the transmitter is held busy
    hold_busy = 1'b1;
    base = n_start;
    drive(1, 8'h41, 0, 8'h00, 1);
    wait_starts(base + 1, 20, "ovf_first_start");
    repeat (3) @(negedge clk);
    drops0 = n_drop_a;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = (i == 7) ? 8'h0A : (i == 8) ? 8'h77 : 8'(8'h50 + i);
      drive(1, b, 0, 8'h00, i < 8);
      if (i == 6) check_val("full_before_8th", ifc.full_a, 0);
      if (i == 7) check_val("full_after_8th",  ifc.full_a, 1);
    end
    repeat (3) @(negedge clk);
    check_val("full_held", ifc.full_a, 1);
    check_val("drop_once", n_drop_a - drops0, 1);
    check_val("full_b_idle", ifc.full_b, 0);
    hold_busy = 1'b0;
    wait_drain(600, "ovf_drain");
    check_val("ovf_count", n_start - base, 9);
    check_val("full_cleared", ifc.full_a, 0);

    // A byte with no EOL holds the grant until the stall timeout
    base = n_start;
    drive(1, 8'h41, 0, 8'h00, 1);
    wait_starts(base + 1, 20, "stall_a_start");
    drive(0, 8'h00, 1, 8'h42, 1);
    drive(0, 8'h00, 1, 8'h0A, 1);
    for (int i = 0; i < 100 && ifc.tx_busy; i++) @(posedge clk);
    check_val("stall_busy_fell", ifc.tx_busy, 0);
    allow_stall = 1'b1;
    repeat (STALL) @(negedge clk);
    check_val("stall_hold_owner", ifc.owner, 2'b01);
    check_val("stall_b_blocked", n_start - base, 1);
    @(negedge clk);
    check_val("stall_release", ifc.owner, 2'b00);
    @(negedge clk);
    check_val("stall_regrant", ifc.owner, 2'b10);
    wait_drain(300, "stall_drain");
    allow_stall = 1'b0;
    check_val("stall_count", n_start - base, 3);

    // Reset one cycle after a start pulse with bytes still queued
    drive(1, 8'h61, 0, 8'h00, 1);
    drive(1, 8'h62, 0, 8'h00, 1);
    drive(1, 8'h63, 0, 8'h00, 1);
    check_val("mid_start_seen", ifc.tx_start, 1);
    drive(1, 8'h0A, 0, 8'h00, 1);
    rst = 1'b1;
    qa.delete();
    drive(1, 8'hEE, 1, 8'hEF, 0);
    check_val("mid_rst_start", ifc.tx_start, 0);
    check_val("mid_rst_owner", ifc.owner, 2'b00);
    check_val("mid_rst_full",  {ifc.full_a, ifc.full_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    base = n_start;
    repeat (3) @(negedge clk);
    check_val("post_rst_quiet", n_start - base, 0);
    drive(1, 8'h71, 0, 8'h00, 1);
    drive(1, 8'h0A, 0, 8'h00, 1);
    wait_drain(200, "post_rst_drain");
    check_val("post_rst_count", n_start - base, 2);

    check_val("sb_leftover", qa.size() + qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per requester FIFO (power of 2).
REQ-002 Parameter EOL_CHAR, default 8'd10, line-feed byte that ends a frame.
REQ-003 Parameter STALL_LIMIT, default 1000, idle cycles after which a stalled owner loses the grant.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 sign_a  input  8  requester A byte (measurement stream).
REQ-007 tick_a  input  1  requester A write strobe, one byte per high cycle.
REQ-008 sign_b  input  8  requester B byte (status/command replies).
REQ-009 tick_b  input  1  requester B write strobe.
REQ-010 tx_busy  input  1  UART transmitter busy flag.
REQ-011 tx_data  output  8  byte presented to the UART transmitter, registered.
REQ-012 tx_start  output  1  one-cycle start pulse to the transmitter, registered.
REQ-013 full_a, full_b  output  1 each  FIFO count equals FIFO_DEPTH.
REQ-014 drop_a, drop_b  output  1 each  one-cycle pulse when a byte is discarded on a full FIFO.
REQ-015 owner  output  2  current grant: 2'b00 none, 2'b01 A, 2'b10 B.

Function
REQ-016 Each requester SHALL have its own FIFO; write accepted when tick is high and count < FIFO_DEPTH at the start of that cycle; no write-to-read bypass.
REQ-017 A tick on a full FIFO SHALL leave contents unchanged and pulse drop_x high for exactly one cycle, even if a pop occurs the same cycle.
REQ-018 Simultaneous push and pop on one non-full FIFO SHALL keep count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 State machine: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE with owner none: only one FIFO non-empty -> grant it; both non-empty -> grant the port opposite last_grant; go to LOAD.
REQ-021 IDLE with owner set and owner FIFO non-empty -> LOAD; otherwise stay, incrementing a stall counter.
REQ-022 Stall counter reaching STALL_LIMIT SHALL clear owner to none and reset the counter; counter SHALL clear on every LOAD.
REQ-023 LOAD: pop owner FIFO head into tx_data -> START.
REQ-024 START: tx_start high for exactly one cycle -> WAIT_BUSY.
REQ-025 WAIT_BUSY: stay until tx_busy = 1 -> WAIT_DONE.
REQ-026 WAIT_DONE: stay until tx_busy = 0; if the sent byte equals EOL_CHAR, set last_grant = owner and owner = none; -> IDLE.
REQ-027 tx_data SHALL stay stable from LOAD until WAIT_DONE exits.
REQ-028 Latency: tick high in cycle 0 with arbiter IDLE, FIFO empty and owner none or same port -> tx_start high in cycle 3.
REQ-029 Bytes of a granted frame SHALL be transmitted contiguously; the other port's bytes never interleave before EOL_CHAR or stall release.
REQ-030 Writes to the non-owning FIFO SHALL continue to be accepted while the other port owns the transmitter.

Reset
REQ-031 rst high at a clock edge SHALL, from any state, return to IDLE, flush both FIFOs (count 0), clear the stall counter, set owner = 2'b00 and last_grant = B.
REQ-032 Reset values: tx_data = 8'h00, tx_start = 0, full_a = full_b = 0, drop_a = drop_b = 0, owner = 2'b00.
REQ-033 Reset mid-transmission SHALL drop the in-flight byte with no further tx_start; ticks during reset SHALL be ignored.

Verification
REQ-034 A writes "V01\n" (8'h56,8'h30,8'h31,8'h0A) with tx_busy held 10 cycles per byte -> four tx_start pulses in order, first in cycle 3, owner returns to 00 after 8'h0A.
REQ-035 A and B each write a 3-byte frame ending 8'h0A in the same cycles after reset -> A frame fully sent, then B frame, no interleave.
REQ-036 9 consecutive tick_a with transmitter stalled busy -> full_a high after 8th write, drop_a pulses once, 8 bytes later sent intact.
REQ-037 A writes 8'h41 without EOL, then B writes 8'h42,8'h0A -> B blocked until STALL_LIMIT idle cycles, then owner = 10 and B frame sent.
REQ-038 rst asserted one cycle after a tx_start with bytes queued -> tx_start stays 0, owner = 00, full flags 0, next frame after reset starts from its first byte.
